// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and default constants for the register bus arbiter
package reg_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK, LOCKED} state_t;

    typedef logic req_id_t;

    localparam logic [7:0] DEF_BASE         = 8'h40;
    localparam int         DEF_DEPTH        = 20;
    localparam int         DEF_LOCK_TIMEOUT = 255;

endpackage

// File: rtl/reg_arb_lock_timer.sv
// reg_arb_lock_timer: 8-bit idle counter, tc pulses on the LIMIT-th consecutive increment
module reg_arb_lock_timer
    import reg_arb_pkg::*;
#(
    parameter int LIMIT = DEF_LOCK_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [7:0] cnt;

    assign tc = inc && (cnt == 8'(LIMIT - 1));

    // count idle cycles; restart on clear or on reaching the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clr || tc) cnt <= '0;
        else if (inc) cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-requester round-robin arbiter with range check and lock for the parameter register file
// Optional: define REG_ARB_ERR_CNT_EN to add a saturating err_count output.
module reg_bus_arbiter
    import reg_arb_pkg::*;
#(
    parameter logic [7:0] BASE         = DEF_BASE,
    parameter int         DEPTH        = DEF_DEPTH,
    parameter int         LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_req,
    input  logic       r0_we,
    input  logic       r0_lock,
    input  logic [7:0] r0_index,
    input  logic [7:0] r0_wdata,
    output logic       r0_ack,
    output logic       r0_err,
    output logic [7:0] r0_rdata,
    input  logic       r1_req,
    input  logic       r1_we,
    input  logic       r1_lock,
    input  logic [7:0] r1_index,
    input  logic [7:0] r1_wdata,
    output logic       r1_ack,
    output logic       r1_err,
    output logic [7:0] r1_rdata,
    output logic       lock_abort,
    output logic       reg_write,
    output logic       reg_read,
    output logic [7:0] reg_index,
    output logic [7:0] reg_data_in,
    input  logic [7:0] reg_data_out
`ifdef REG_ARB_ERR_CNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [8:0] LIM = 9'(BASE) + 9'(DEPTH);

    state_t     state, state_n;
    req_id_t    winner, winner_n, rr_ptr, rr_n, owner, owner_n, sel;
    logic       we_q, we_n, lock_q, lock_n, rng_q, rng_n;
    logic       grant, sel_we, sel_lock, sel_rng;
    logic [7:0] sel_index, sel_wdata;
    logic       write_n, read_n, ack0_n, ack1_n, err_n, abort_n;
    logic [7:0] index_n, data_n, rdata_n;
    logic       tmr_clr, tmr_inc, tmr_tc;

    assign sel       = (state == LOCKED) ? owner : (r1_req & (~r0_req | rr_ptr));
    assign grant     = (state == IDLE) ? (r0_req | r1_req) :
                       (state == LOCKED) ? (sel ? r1_req : r0_req) : 1'b0;
    assign sel_we    = sel ? r1_we : r0_we;
    assign sel_lock  = sel ? r1_lock : r0_lock;
    assign sel_index = sel ? r1_index : r0_index;
    assign sel_wdata = sel ? r1_wdata : r0_wdata;
    assign sel_rng   = (sel_index >= BASE) && ({1'b0, sel_index} < LIM);

    assign tmr_inc = (state == LOCKED) && !grant;
    assign tmr_clr = (state == ACK) || grant;

    reg_arb_lock_timer #(.LIMIT(LOCK_TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .inc (tmr_inc),
        .tc  (tmr_tc)
    );

    // next state, latched transaction fields and next values of the registered outputs
    always_comb begin
        state_n  = state;
        winner_n = winner;
        we_n     = we_q;
        lock_n   = lock_q;
        rng_n    = rng_q;
        rr_n     = rr_ptr;
        owner_n  = owner;
        write_n  = 1'b0;
        read_n   = 1'b0;
        index_n  = '0;
        data_n   = '0;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        err_n    = 1'b0;
        rdata_n  = '0;
        abort_n  = 1'b0;
        case (state)
            IDLE, LOCKED: begin
                if (grant) begin
                    state_n  = ACCESS;
                    winner_n = sel;
                    we_n     = sel_we;
                    lock_n   = sel_lock;
                    rng_n    = sel_rng;
                    write_n  = sel_rng & sel_we;
                    read_n   = sel_rng & ~sel_we;
                    index_n  = sel_rng ? sel_index - BASE : '0;
                    data_n   = sel_rng ? sel_wdata : '0;
                end else if (tmr_tc) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                    rr_n    = ~owner;
                end
            end
            ACCESS: begin
                state_n = ACK;
                ack0_n  = ~winner;
                ack1_n  = winner;
                err_n   = ~rng_q;
                rdata_n = (rng_q && !we_q) ? reg_data_out : '0;
            end
            ACK: begin
                if (lock_q) begin
                    state_n = LOCKED;
                    owner_n = winner;
                end else begin
                    state_n = IDLE;
                    rr_n    = ~winner;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, arbitration bookkeeping and all outputs are flops so strobes and acks are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            winner      <= 1'b0;
            we_q        <= 1'b0;
            lock_q      <= 1'b0;
            rng_q       <= 1'b0;
            rr_ptr      <= 1'b0;
            owner       <= 1'b0;
            reg_write   <= 1'b0;
            reg_read    <= 1'b0;
            reg_index   <= '0;
            reg_data_in <= '0;
            r0_ack      <= 1'b0;
            r1_ack      <= 1'b0;
            r0_err      <= 1'b0;
            r1_err      <= 1'b0;
            r0_rdata    <= '0;
            r1_rdata    <= '0;
            lock_abort  <= 1'b0;
        end else begin
            state       <= state_n;
            winner      <= winner_n;
            we_q        <= we_n;
            lock_q      <= lock_n;
            rng_q       <= rng_n;
            rr_ptr      <= rr_n;
            owner       <= owner_n;
            reg_write   <= write_n;
            reg_read    <= read_n;
            reg_index   <= index_n;
            reg_data_in <= data_n;
            r0_ack      <= ack0_n;
            r1_ack      <= ack1_n;
            r0_err      <= ack0_n & err_n;
            r1_err      <= ack1_n & err_n;
            r0_rdata    <= ack0_n ? rdata_n : '0;
            r1_rdata    <= ack1_n ? rdata_n : '0;
            lock_abort  <= abort_n;
        end
    end

`ifdef REG_ARB_ERR_CNT_EN
    // count error acks and lock timeouts, saturating at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_count <= '0;
        else if ((r0_err || r1_err || lock_abort) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed self-checking bench for reg_bus_arbiter with a small register file model
module tb_reg_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0_req = 1'b0, r0_we = 1'b0, r0_lock = 1'b0;
    logic [7:0] r0_index = '0, r0_wdata = '0;
    logic       r1_req = 1'b0, r1_we = 1'b0, r1_lock = 1'b0;
    logic [7:0] r1_index = '0, r1_wdata = '0;
    logic       r0_ack, r0_err, r1_ack, r1_err, lock_abort;
    logic [7:0] r0_rdata, r1_rdata;
    logic       reg_write, reg_read;
    logic [7:0] reg_index, reg_data_in, reg_data_out;
`ifdef REG_ARB_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] rf [0:19];

    always #5 clk = ~clk;

    reg_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .r0_req       (r0_req),
        .r0_we        (r0_we),
        .r0_lock      (r0_lock),
        .r0_index     (r0_index),
        .r0_wdata     (r0_wdata),
        .r0_ack       (r0_ack),
        .r0_err       (r0_err),
        .r0_rdata     (r0_rdata),
        .r1_req       (r1_req),
        .r1_we        (r1_we),
        .r1_lock      (r1_lock),
        .r1_index     (r1_index),
        .r1_wdata     (r1_wdata),
        .r1_ack       (r1_ack),
        .r1_err       (r1_err),
        .r1_rdata     (r1_rdata),
        .lock_abort   (lock_abort),
        .reg_write    (reg_write),
        .reg_read     (reg_read),
        .reg_index    (reg_index),
        .reg_data_in  (reg_data_in),
`ifdef REG_ARB_ERR_CNT_EN
        .err_count    (err_count),
`endif
        .reg_data_out (reg_data_out)
    );

    // register file model: synchronous write, combinational read
    assign reg_data_out = (reg_index < 8'd20) ? rf[reg_index[4:0]] : 8'h00;

    always @(posedge clk) begin
        if (reg_write && reg_index < 8'd20) rf[reg_index[4:0]] <= reg_data_in;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic req, input logic we, input logic lk,
                         input logic [7:0] idx, input logic [7:0] wd);
        if (id == 0) begin
            r0_req = req; r0_we = we; r0_lock = lk; r0_index = idx; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_lock = lk; r1_index = idx; r1_wdata = wd;
        end
    endtask

    task automatic xact(input int id, input logic we, input logic lk, input logic [7:0] idx,
                        input logic [7:0] wd, output logic [7:0] rd, output logic e, output logic stb);
        logic got;
        got = 1'b0; stb = 1'b0; rd = '0; e = 1'b0;
        drive(id, 1'b1, we, lk, idx, wd);
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            stb = stb | reg_write | reg_read;
            if (id == 0 ? r0_ack : r1_ack) begin
                got = 1'b1;
                rd  = id == 0 ? r0_rdata : r1_rdata;
                e   = id == 0 ? r0_err : r1_err;
            end
        end
        drive(id, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        if (!got) chk("xact_ack_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        logic [7:0] rd_a, rd_b;
        logic       e_a, e_b, s_a, s_b, seen;
        int         cyc;

        for (int i = 0; i < 20; i++) rf[i] = 8'h00;
        repeat (3) tick();
        chk("reset_outs", {reg_write, reg_read, r0_ack, r1_ack, r0_err, r1_err, lock_abort}, 32'd0);
        chk("reset_data", {reg_index, reg_data_in, r0_rdata, r1_rdata}, 32'd0);
        rst = 1'b0;
        tick();

        // single write by r0, then read back by r1
        drive(0, 1'b1, 1'b1, 1'b0, 8'h40, 8'hAB);
        tick();
        chk("t1_wr_strobe", {reg_write, reg_read, r0_ack}, 32'b100);
        chk("t1_wr_index", reg_index, 8'h00);
        chk("t1_wr_data", reg_data_in, 8'hAB);
        tick();
        chk("t1_ack", {r0_ack, r0_err, r1_ack, reg_write}, 32'b1000);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        drive(1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
        tick();
        chk("t1_rd_strobe", {reg_write, reg_read, reg_index}, {2'b01, 8'h00});
        tick();
        chk("t1_rd_ack", {r1_ack, r1_err, r0_ack}, 32'b100);
        chk("t1_rd_data", r1_rdata, 8'hAB);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // simultaneous requests from reset: r0 first, then r1, then r0 again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 8'h44, 8'h11);
        drive(1, 1'b1, 1'b1, 1'b0, 8'h45, 8'h22);
        tick();
        chk("t2_first_grant", {reg_write, reg_index, reg_data_in}, {1'b1, 8'h04, 8'h11});
        tick();
        chk("t2_first_ack", {r0_ack, r1_ack}, 32'b10);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk("t2_second_grant", {reg_write, reg_index, reg_data_in}, {1'b1, 8'h05, 8'h22});
        tick();
        chk("t2_second_ack", {r0_ack, r1_ack}, 32'b01);
        drive(0, 1'b1, 1'b1, 1'b0, 8'h46, 8'h33);
        tick();
        tick();
        chk("t2_third_grant", {reg_write, reg_index, reg_data_in}, {1'b1, 8'h06, 8'h33});
        tick();
        chk("t2_third_ack", {r0_ack, r1_ack}, 32'b10);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();

        // r1 locked two-byte write of pwm_period while r0 keeps requesting
        drive(1, 1'b1, 1'b1, 1'b1, 8'h40, 8'h12);
        drive(0, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
        tick();
        chk("t3_lo_strobe", {reg_write, reg_index, reg_data_in}, {1'b1, 8'h00, 8'h12});
        tick();
        chk("t3_lo_ack", {r0_ack, r1_ack}, 32'b01);
        drive(1, 1'b1, 1'b1, 1'b0, 8'h41, 8'h34);
        tick();
        chk("t3_locked_idle", {reg_write, reg_read, r0_ack, r1_ack}, 32'd0);
        tick();
        chk("t3_hi_strobe", {reg_write, reg_index, reg_data_in}, {1'b1, 8'h01, 8'h34});
        tick();
        chk("t3_hi_ack", {r0_ack, r1_ack}, 32'b01);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        chk("t3_r0_strobe", {reg_read, reg_index}, {1'b1, 8'h00});
        tick();
        chk("t3_r0_ack", {r0_ack, r1_ack}, 32'b10);
        rd_a = r0_rdata;
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        xact(0, 1'b0, 1'b0, 8'h41, 8'h00, rd_b, e_b, s_b);
        chk("t3_pwm_period", {rd_a, rd_b}, 16'h1234);

        // out-of-range reads above and below the window
        xact(0, 1'b0, 1'b0, 8'h54, 8'h00, rd_a, e_a, s_a);
        chk("t4_hi_err", {e_a, s_a, rd_a}, {2'b10, 8'h00});
        xact(0, 1'b0, 1'b0, 8'h3F, 8'h00, rd_b, e_b, s_b);
        chk("t4_lo_err", {e_b, s_b, rd_b}, {2'b10, 8'h00});
        xact(0, 1'b0, 1'b0, 8'h53, 8'h00, rd_a, e_a, s_a);
        chk("t4_top_slot", {e_a, s_a}, 32'b01);
`ifdef REG_ARB_ERR_CNT_EN
        chk("t4_err_count", err_count, 8'd2);
`endif

        // locked write then silence: lock times out and waiting r1 is served
        drive(0, 1'b1, 1'b1, 1'b1, 8'h42, 8'h55);
        tick();
        tick();
        chk("t5_lock_ack", r0_ack, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b1, 1'b0, 8'h43, 8'h66);
        seen = 1'b0;
        cyc = 0;
        for (int k = 0; k < 300 && !lock_abort; k++) begin
            tick();
            cyc++;
            seen = seen | r1_ack | reg_write;
        end
        chk("t5_abort_cycles", cyc, 256);
        chk("t5_no_grant_in_lock", seen, 1'b0);
        tick();
        chk("t5_r1_strobe", {reg_write, reg_index, reg_data_in, lock_abort}, {1'b1, 8'h03, 8'h66, 1'b0});
        tick();
        chk("t5_r1_ack", {r1_ack, r1_err}, 32'b10);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
`ifdef REG_ARB_ERR_CNT_EN
        chk("t5_err_count", err_count, 8'd3);
`endif

        // asynchronous reset during ACCESS
        drive(0, 1'b1, 1'b1, 1'b0, 8'h47, 8'h77);
        tick();
        chk("t6_pre_reset", reg_write, 1'b1);
        drive(1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00);
        #1 rst = 1'b1;
        #1 chk("t6_async_drop", {reg_write, reg_read}, 32'd0);
        tick();
        chk("t6_no_ack", {r0_ack, r1_ack}, 32'd0);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("t6_r1_strobe", {reg_read, reg_index}, {1'b1, 8'h00});
        tick();
        chk("t6_r1_ack", {r1_ack, r0_ack, r1_rdata}, {2'b10, 8'h12});
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
`ifdef REG_ARB_ERR_CNT_EN
        chk("t6_err_count", err_count, 8'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
